// File: rtl/response_demux_pkg.sv
// Shared definitions for the request mux / response demux pair.
// Holds the consumer-ID type so the request-mux select and the demux
// issue_id are the same type, the helper that sizes it, and the
// hold-stage state encoding.
package response_demux_pkg;

  localparam int NUM_CONSUMERS = 8;

  // Width of a consumer index; never below one bit so a 1-consumer
  // configuration still produces a legal vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [id_width(NUM_CONSUMERS)-1:0] consumer_id_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/response_demux_id_fifo.sv
// In-order FIFO of consumer IDs waiting for their response.
// Ports:
//   clk, rst (async, active-low)
//   push, push_data  - write an entry (ignored while full)
//   pop, pop_data    - head entry, removed on pop (ignored while empty)
//   full, empty      - occupancy flags, derived from the registered count
//   count            - current number of entries
// Because full/empty come from the registered count, an entry written
// in one cycle is only visible at the head from the next cycle on.
module id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only slots between the pointers are read.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/response_demux.sv
// Routes in-order responses from a shared resource back to the consumer
// whose request was forwarded first, using a FIFO of issued IDs and a
// single-entry output holding stage.
// Ports:
//   clk, rst (async, active-low)
//   issue_valid, issue_id, issue_ready - record the ID of a forwarded request
//   resp_valid, resp_data, resp_ready  - in-order response stream
//   out_valid, out_data, out_ready     - per-consumer delivery
//   outstanding                        - IDs waiting for a response
//   err_unexpected                     - pulse after a response with nothing outstanding
module response_demux
  import response_demux_pkg::*;
#(
  parameter int REQ_NUMBER = 8,
  parameter int REQ_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [id_width(REQ_NUMBER)-1:0]    issue_id,
  output logic                               issue_ready,
  input  logic                               resp_valid,
  input  logic [REQ_WIDTH-1:0]               resp_data,
  output logic                               resp_ready,
  output logic [REQ_NUMBER-1:0]              out_valid,
  output logic [REQ_WIDTH-1:0]               out_data [REQ_NUMBER],
  input  logic [REQ_NUMBER-1:0]              out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    outstanding,
  output logic                               err_unexpected
);

  localparam int ID_W = id_width(REQ_NUMBER);

  hold_state_t          state;
  hold_state_t          next_state;
  logic [ID_W-1:0]      hold_id;
  logic [ID_W-1:0]      head_id;
  logic [REQ_WIDTH-1:0] hold_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 hold_ready;
  logic                 accept;
  logic                 drain;

  id_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue_valid),
    .push_data (issue_id),
    .pop       (accept),
    .pop_data  (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // issue_ready comes from the registered count only, so a pop frees a
  // slot in the next cycle and out_ready never reaches issue_ready.
  assign issue_ready = !fifo_full;
  assign hold_ready  = out_ready[hold_id];
  assign resp_ready  = !fifo_empty && ((state == HOLD_EMPTY) || hold_ready);
  assign accept      = resp_valid && resp_ready;
  assign drain       = (state == HOLD_FULL) && hold_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HOLD_EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // A new acceptance always leaves the stage full, even when the old
  // contents drain in the same cycle; that keeps one response per cycle.
  always_comb begin
    next_state = state;
    out_valid  = '0;
    case (state)
      HOLD_EMPTY: if (accept) next_state = HOLD_FULL;
      HOLD_FULL:  if (drain && !accept) next_state = HOLD_EMPTY;
      default:    next_state = HOLD_EMPTY;
    endcase
    for (int i = 0; i < REQ_NUMBER; i++) begin
      out_valid[i] = (state == HOLD_FULL) && (hold_id == ID_W'(i));
      out_data[i]  = hold_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_id        <= '0;
      hold_data      <= '0;
      err_unexpected <= 1'b0;
    end else begin
      if (accept) begin
        hold_id   <= head_id;
        hold_data <= resp_data;
      end
      err_unexpected <= resp_valid && fifo_empty;
    end
  end

endmodule

// File: doc/response_demux.md
RESPONSE_DEMUX -- requirements
Module: response_demux

Interface
REQ-001 Parameter REQ_NUMBER, default 8, number of consumer ports; SHALL be >= 2.
REQ-002 Parameter REQ_WIDTH, default 32, response data width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4, maximum outstanding issued requests; SHALL be a power of two >= 2.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 issue_valid  input  1  a request to consumer issue_id was forwarded this cycle.
REQ-007 issue_id  input  $clog2(REQ_NUMBER)  index of the issuing consumer (the request-mux select value).
REQ-008 issue_ready  output  1  ID FIFO can accept an entry.
REQ-009 resp_valid  input  1  in-order response available from the shared resource.
REQ-010 resp_data  input  REQ_WIDTH  response payload.
REQ-011 resp_ready  output  1  response accepted when resp_valid && resp_ready.
REQ-012 out_valid  output  REQ_NUMBER  per-consumer response valid; at most one bit set.
REQ-013 out_data  output  unpacked array [REQ_NUMBER] of REQ_WIDTH  per-consumer response payload.
REQ-014 out_ready  input  REQ_NUMBER  per-consumer ready.
REQ-015 outstanding  output  $clog2(FIFO_DEPTH+1)  current ID FIFO occupancy.
REQ-016 err_unexpected  output  1  one-cycle pulse flagging a response with no outstanding ID.

Function
REQ-017 The block SHALL record issue_id in an in-order FIFO on every cycle with issue_valid && issue_ready.
REQ-018 issue_ready SHALL be 1 iff outstanding < FIFO_DEPTH; issue_valid while issue_ready=0 SHALL be ignored and SHALL NOT corrupt state.
REQ-019 A single holding stage (hold_valid, hold_id, hold_data) SHALL form a two-state machine: EMPTY (hold_valid=0) and FULL (hold_valid=1).
REQ-020 resp_ready SHALL equal (outstanding != 0) && (EMPTY || out_ready[hold_id]), computed combinationally.
REQ-021 On resp_valid && resp_ready, the FIFO head SHALL pop into hold_id, resp_data SHALL load into hold_data, and the state SHALL become or remain FULL; latency is 1 cycle from acceptance to out_valid.
REQ-022 In FULL, out_valid[hold_id] SHALL be 1 and all other bits 0; every out_data[i] SHALL equal hold_data.
REQ-023 FULL -> EMPTY SHALL occur when out_ready[hold_id]=1 and no new response is accepted in the same cycle.
REQ-024 Simultaneous drain and accept SHALL replace the hold contents in one cycle, sustaining one response per cycle.
REQ-025 Simultaneous push and pop SHALL leave outstanding unchanged; pop at FIFO_DEPTH SHALL make issue_ready=1 in the next cycle, not combinationally.
REQ-026 An ID pushed in cycle N SHALL NOT be poppable before cycle N+1; there is no FIFO bypass.
REQ-027 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated IDs.
REQ-028 err_unexpected SHALL be registered and SHALL assert for one cycle following each cycle with resp_valid=1 and outstanding=0.
REQ-029 out_ready bits other than out_ready[hold_id] SHALL have no effect.

Reset
REQ-030 While rst=0: FIFO empty, outstanding=0, state EMPTY, out_valid=0, hold_data=0, hold_id=0, err_unexpected=0, issue_ready=1, resp_ready=0.
REQ-031 Assertion of rst mid-operation SHALL discard all outstanding IDs and any held response immediately; nothing SHALL be delivered after release until new issues are made.

Structure
REQ-032 The consumer-ID typedef and its width helper SHALL reside in the shared package used by request_mux, so that select and issue_id share one type.
REQ-033 The ID FIFO SHALL be a separate sub-module, id_fifo (parameters DEPTH and WIDTH; push/pop/full/empty/count).
REQ-034 Target size is 120-400 RTL lines in total; no multi-cycle combinational paths from out_ready to issue_ready.

Verification
REQ-035 Issue ids 3, 5, 0; responses 3000, 5000, 0 with all out_ready=1 -> out_valid[3] with data 3000, then [5] with 5000, then [0] with 0, on consecutive cycles after 1-cycle latency.
REQ-036 Issue 4 IDs (FIFO full) -> issue_ready=0 and outstanding=4; a 5th issue_valid is ignored; after 1 response pop, issue_ready=1 on the next cycle.
REQ-037 Hold out_ready[7]=0 with id 7 held and a second response pending -> resp_ready=0 and data stable at 7000; release -> both delivered in order, no loss.
REQ-038 resp_valid=1 with outstanding=0 -> resp_ready=0, err_unexpected pulses exactly once per such cycle, and out_valid stays 0.
REQ-039 Push 10 IDs through a depth-4 FIFO with interleaved push/pop (pointer wrap) -> delivery order equals issue order, and outstanding returns to 0.
REQ-040 Assert rst with 2 IDs outstanding and one response held -> out_valid=0 and outstanding=0 immediately; after release, no stale delivery occurs.
